// File: rtl/simd_mem_pkg.sv
// Shared definitions for the SIMD operand memory path: default geometry,
// word/address types and the stream-reader state encoding.
package simd_mem_pkg;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_DEPTH      = 256;
    localparam int DEF_ADDR_W     = $clog2(DEF_DEPTH);

    typedef logic [DEF_ADDR_W-1:0]     addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO with a valid/ready output side. The head entry
// always sits in head_q so out_data is a plain register and stays stable
// while stalled.
module stream_fifo2 #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;
    logic             push_ok;

    assign pop     = pop_ready && (count_q != 2'd0);
    assign push_ok = push && ((count_q != 2'd2) || pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = push_data;
                else                 tail_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; when full the tail shifts forward.
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;
endmodule

// File: rtl/bram_stream_reader.sv
// Sequential BRAM reader presenting words on a valid/ready stream.
// Optional BRAM_STREAM_READER_STRIDE_EN adds a per-transfer address stride.
module bram_stream_reader
    import simd_mem_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
`ifdef BRAM_STREAM_READER_STRIDE_EN
    input  logic [ADDR_W-1:0]     stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]   beat_cnt_q, beat_cnt_d;
    logic              inflight_q;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W:0]   addr_sum;
    logic [ADDR_W:0]   addr_wrap;
    logic [ADDR_W-1:0] addr_next;
    logic              issue;
    logic              hs;
    logic              fifo_valid;
    logic [1:0]        fifo_count;
    logic [1:0]        occ;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    logic [ADDR_W-1:0] stride_q, stride_d;
    assign step = stride_q;
`else
    assign step = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    assign addr_sum  = {1'b0, addr_q} + {1'b0, step};
    assign addr_wrap = (addr_sum >= DEPTH_EXT) ? (addr_sum - DEPTH_EXT) : addr_sum;
    assign addr_next = addr_wrap[ADDR_W-1:0];

    assign hs  = fifo_valid && m_ready;
    assign occ = fifo_count + {1'b0, inflight_q};
    // A beat leaving this cycle frees its slot for an issue in the same cycle.
    assign issue = (state_q == RUN) && (issue_cnt_q != '0) && ((occ != 2'd2) || hs);

    assign mem_addr = issue ? addr_q : mem_addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
`ifdef BRAM_STREAM_READER_STRIDE_EN
        stride_d    = stride_q;
`endif
        if (hs) beat_cnt_d = beat_cnt_q - CNT_ONE;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = RUN;
                        addr_d      = base_addr;
                        issue_cnt_d = length;
                        beat_cnt_d  = length;
`ifdef BRAM_STREAM_READER_STRIDE_EN
                        stride_d    = stride;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_next;
                    issue_cnt_d = issue_cnt_q - CNT_ONE;
                    if (issue_cnt_q == CNT_ONE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs && (beat_cnt_q == CNT_ONE)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef BRAM_STREAM_READER_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr;
            issue_cnt_q <= issue_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            inflight_q  <= issue;
            done_q      <= done_d;
`ifdef BRAM_STREAM_READER_STRIDE_EN
            stride_q    <= stride_d;
`endif
        end
    end

    stream_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .pop_ready (m_ready),
        .out_valid (fifo_valid),
        .out_data  (m_data),
        .count     (fifo_count)
    );

    assign m_valid = fifo_valid;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign mem_we  = 1'b0;
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side client for the single-port block RAM: given a base address and word count, it issues sequential BRAM reads, absorbs the fixed 1-cycle read latency, and presents the words on a valid/ready stream with full backpressure. It sits between a vector register/operand BRAM and the SIMD datapath's operand input. It sustains one word per cycle when the consumer is always ready.

## Interface
- DATA_WIDTH, 128: width of one BRAM word and of one stream beat.
- DEPTH, 256: BRAM word count; ADDR_W = $clog2(DEPTH).

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while idle (busy=0).
- base_addr  in  ADDR_W  first word address, captured with start.
- length  in  ADDR_W+1  number of words to read, 0..DEPTH, captured with start.
- busy  out  1  high from the edge that accepts start until the done edge.
- done  out  1  one-cycle pulse when the last beat has been accepted.
- mem_addr  out  ADDR_W  BRAM address.
- mem_we  out  1  constant 0; the block never writes.
- mem_rdata  in  DATA_WIDTH  BRAM data_out, valid the cycle after an address is issued.
- m_valid  out  1  stream beat valid.
- m_data  out  DATA_WIDTH  stream beat data.
- m_ready  in  1  consumer accepts the beat when m_valid and m_ready are both high.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 and length>0 → RUN. The block latches base_addr into addr_q, loads issue_cnt=length and beat_cnt=length, and sets busy=1.
- IDLE: start=1 and length=0 → no reads are issued. busy stays 0 and done pulses on the next cycle.
- RUN: a read issues in a cycle when issue_cnt>0 and credits are available, where fifo_count + inflight < 2.
  - Issue drives mem_addr=addr_q, then addr_q increments with wrap modulo DEPTH (DEPTH-1 → 0). issue_cnt decrements.
  - inflight is 1 in the cycle after an issue. The returning mem_rdata is written into the 2-entry output FIFO at that cycle's closing edge.
- RUN → DRAIN when issue_cnt reaches 0.
- DRAIN → IDLE on the handshake that takes beat_cnt to 0. done=1 for the following cycle and busy drops on that same edge.
- beat_cnt decrements on each m_valid&&m_ready.
- start while busy is ignored and has no effect on latched values.
- m_data and order: words are delivered in address order, with no drops and no duplicates, under any m_ready pattern.
- m_valid, once high, stays high with m_data stable until the handshake.
- mem_addr holds its last value when no read is issued.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_data=0, mem_addr=0, mem_we=0. The FIFO is emptied and all counters are cleared.
- rst_n asserted mid-transfer aborts immediately. No further beats or done are produced after release.
- Latency: start is sampled at edge n, the first mem_addr is issued in cycle n..n+1, and m_valid rises at edge n+2.
- With m_ready held high, beats arrive on consecutive cycles and the last beat is at edge n+1+length. done is high for the cycle after that last handshake.
- With m_ready=0, at most 2 words are buffered and the block stops issuing. The first issue after m_ready returns occurs in the same cycle as the freeing handshake, so there is no throughput bubble.
- length=DEPTH reads every word exactly once, including the wrap.

## Configuration
- BRAM_STREAM_READER_STRIDE_EN defined: adds input stride (ADDR_W). The address advances by the stride captured at start, modulo DEPTH.
- Undefined: no stride port and the address advances by 1.

## Structure
- Shared package simd_mem_pkg holds:
  - ADDR_W / DATA_WIDTH defaults;
  - addr_t and word_t typedefs;
  - the state enum rd_state_e {IDLE, RUN, DRAIN}.
- One natural sub-module: stream_fifo2, a 2-entry registered FIFO with valid/ready output, count, and a simultaneous push/pop in the same cycle when full.

## Test plan
- base=0x10, length=4, m_ready=1, with BRAM word i = i → beats 0x10..0x13 on 4 consecutive cycles from edge n+2; done pulses once; busy is high for 6 cycles.
- base=0xFE, length=4 → beats in order 0xFE, 0xFF, 0x00, 0x01, confirming address wrap.
- length=8 with m_ready toggled by a random 30% duty pattern → 8 beats in order, m_data is stable while stalled, and at most 2 reads are outstanding or buffered.
- length=0 → no mem_addr change and no m_valid; done pulses the cycle after start; busy stays 0.
- start pulsed again mid-transfer with a different base → ignored; the original sequence completes unchanged.
- rst_n low after 3 beats of length=10 → all outputs return to reset values immediately; after release, a new start with base=0, length=2 delivers words 0 and 1 correctly.
